// File: rtl/iir_sample_sequencer_if.sv
// Control/data bundle between the register bank, the sample sequencer and the IIR filter input.
// The master side drives load/start controls; the slave side is the sequencer.
interface iir_sample_sequencer_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   frame_len;
  logic [7:0]    rate_div;
  logic          start;
  logic          abort;
  logic [DW-1:0] sample_o;
  logic          sample_valid_o;
  logic          first_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  modport master (
    output wr_en, wr_addr, wr_data, frame_len, rate_div, start, abort,
    input  sample_o, sample_valid_o, first_o, last_o, busy_o, done_o
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, frame_len, rate_div, start, abort,
    output sample_o, sample_valid_o, first_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/iir_sample_sequencer.sv
// Streams a host-loaded frame of samples into the IIR filter at a programmable cadence,
// then appends FLUSH zero samples to drain the filter pipeline and pulses done.
module iir_sample_sequencer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned FLUSH = 9
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  iir_sample_sequencer_if.slave bus
);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + FLUSH + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSHING} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [LW-1:0] len_q, len_d, eff_len;
  logic [7:0]    rate_q, rate_d, div_q, div_d;
  logic [CW-1:0] idx_q, idx_d, total;
  logic          emit_slot, in_frame;
  logic [DW-1:0] sample_q, sample_d;
  logic          valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic          busy_q, busy_d, done_q, done_d;

  assign eff_len   = (bus.frame_len == '0 || bus.frame_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.frame_len;
  assign total     = CW'(len_q) + CW'(FLUSH);
  assign emit_slot = (state_q != IDLE) && (div_q == rate_q);
  assign in_frame  = idx_q < CW'(len_q);

  // Sample memory: host writes land only while idle; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (bus.wr_en && !busy_q) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One emission counter covers frame samples (idx < L) and flush zeros (L <= idx < L+FLUSH).
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:            if (bus.start) state_d = STREAM;
        STREAM, FLUSHING: begin
          if (emit_slot) begin
            if (idx_q == total) state_d = IDLE;
            else if (in_frame)  state_d = STREAM;
            else                state_d = FLUSHING;
          end
        end
        default:         state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    len_d    = len_q;
    rate_d   = rate_q;
    div_d    = div_q;
    idx_d    = idx_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != IDLE);
    if (bus.abort) begin
      div_d = '0;
      idx_d = '0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        len_d    = eff_len;
        rate_d   = bus.rate_div;
        div_d    = '0;
        idx_d    = CW'(1);
        sample_d = mem[0];
        valid_d  = 1'b1;
        first_d  = 1'b1;
        last_d   = (eff_len == LW'(1));
      end
    end else if (emit_slot) begin
      div_d = '0;
      if (idx_q == total) begin
        done_d = 1'b1;
        idx_d  = '0;
      end else begin
        sample_d = in_frame ? mem[idx_q[AW-1:0]] : '0;
        valid_d  = 1'b1;
        last_d   = (idx_q == CW'(len_q) - CW'(1));
        idx_d    = CW'(idx_q + CW'(1));
      end
    end else begin
      div_d = 8'(div_q + 8'd1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      len_q    <= '0;
      rate_q   <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      len_q    <= len_d;
      rate_q   <= rate_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      first_q  <= first_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.first_o        = first_q;
  assign bus.last_o         = last_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
endmodule

// File: tb/tb_iir_sample_sequencer.sv
// Bench for iir_sample_sequencer: frame table with hand-computed done cycles,
// plus directed abort, back-to-back and mid-flush reset sequences.
module tb_iir_sample_sequencer;
  localparam int unsigned DW = 32, DEPTH = 32, AW = 5, FLUSH = 9;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  iir_sample_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  iir_sample_sequencer #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .FLUSH(FLUSH)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus)
  );

  typedef struct {
    logic [AW:0] frame_len;
    logic [7:0]  rate_div;
    int          exp_len;
    int          done_cyc;
    bit          disturb;
  } frame_vec_t;

  frame_vec_t    vecs [8];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] held;
  int            n_vec, n_bad;

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // exp = {valid, first, last, busy, done, sample}
  task automatic check(input string name, input logic [DW+4:0] exp);
    logic [DW+4:0] act;
    act = {bus.sample_valid_o, bus.first_o, bus.last_o, bus.busy_o, bus.done_o, bus.sample_o};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got vflbd=%b sample=%h, want vflbd=%b sample=%h",
               name, act[DW+4:DW], act[DW-1:0], exp[DW+4:DW], exp[DW-1:0]);
    end
  endtask

  task automatic write_mem(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    ref_mem[a]  = d;
  endtask

  // Launch a frame from IDLE and check every cycle up to and including done_o.
  task automatic run_frame(input int vi, input bit hold);
    frame_vec_t v;
    int d, l, n;
    logic ev, ef, el, eb, ed;
    v = vecs[vi];
    d = int'(v.rate_div);
    l = v.exp_len;
    bus.frame_len = v.frame_len;
    bus.rate_div  = v.rate_div;
    bus.start     = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    for (int c = 1; c <= v.done_cyc; c++) begin
      ev = 1'b0; ef = 1'b0; el = 1'b0;
      if ((c - 1) % (d + 1) == 0 && (c - 1) / (d + 1) < l + int'(FLUSH)) begin
        n    = (c - 1) / (d + 1);
        ev   = 1'b1;
        held = (n < l) ? ref_mem[n] : '0;
        ef   = (n == 0);
        el   = (n == l - 1);
      end
      eb = (c < v.done_cyc);
      ed = (c == v.done_cyc);
      check($sformatf("frame%0d_c%0d", vi, c), {ev, ef, el, eb, ed, held});
      if (v.disturb && c == 3) begin
        bus.wr_en     = 1'b1;
        bus.wr_addr   = AW'(5);
        bus.wr_data   = 32'hDEAD;
        bus.rate_div  = 8'd7;
        bus.frame_len = 6'd3;
      end
      if (v.disturb && c == 4) bus.wr_en = 1'b0;
      if (c < v.done_cyc) tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    held  = '0;
    vecs[0] = '{frame_len: 6'd0,  rate_div: 8'd0, exp_len: 32, done_cyc: 42, disturb: 1'b0};
    vecs[1] = '{frame_len: 6'd4,  rate_div: 8'd2, exp_len: 4,  done_cyc: 40, disturb: 1'b0};
    vecs[2] = '{frame_len: 6'd1,  rate_div: 8'd0, exp_len: 1,  done_cyc: 11, disturb: 1'b0};
    vecs[3] = '{frame_len: 6'd1,  rate_div: 8'd3, exp_len: 1,  done_cyc: 41, disturb: 1'b0};
    vecs[4] = '{frame_len: 6'd40, rate_div: 8'd1, exp_len: 32, done_cyc: 83, disturb: 1'b1};
    vecs[5] = '{frame_len: 6'd33, rate_div: 8'd0, exp_len: 32, done_cyc: 42, disturb: 1'b0};
    vecs[6] = '{frame_len: 6'd32, rate_div: 8'd0, exp_len: 32, done_cyc: 42, disturb: 1'b0};
    vecs[7] = '{frame_len: 6'd7,  rate_div: 8'd5, exp_len: 7,  done_cyc: 97, disturb: 1'b0};

    wb_rst_i      = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.frame_len = '0;
    bus.rate_div  = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    tick();
    tick();
    check("reset", '0);
    wb_rst_i = 1'b0;
    tick();
    check("idle_after_reset", '0);

    for (int i = 0; i < int'(DEPTH); i++) write_mem(i, DW'(i + 1));

    for (int vi = 0; vi < 8; vi++) begin
      if (vi == 1) begin
        write_mem(0, 32'hA);
        write_mem(1, 32'hB);
        write_mem(2, 32'hC);
        write_mem(3, 32'hD);
      end
      run_frame(vi, 1'b0);
      tick();
      check($sformatf("post_frame%0d", vi), {5'b00000, held});
    end

    // Abort on the third sample, together with start.
    bus.frame_len = 6'd8;
    bus.rate_div  = 8'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("abort_third_sample", {5'b10010, ref_mem[2]});
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    check("abort_next_cycle", {5'b00000, ref_mem[2]});
    tick();
    check("abort_beats_start_idle", {5'b00000, ref_mem[2]});
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("abort_quiet_c%0d", c), {5'b00000, ref_mem[2]});
    end
    run_frame(1, 1'b0);

    // start held through done: next frame begins the following cycle.
    run_frame(2, 1'b1);
    tick();
    check("back_to_back_first", {5'b11110, ref_mem[0]});
    held = ref_mem[0];
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("back_to_back_aborted", {5'b00000, held});

    // Asynchronous reset during FLUSH.
    bus.frame_len = 6'd2;
    bus.rate_div  = 8'd0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_flush", {5'b10010, 32'h0});
    #2 wb_rst_i = 1'b1;
    #1 check("async_reset_immediate", '0);
    tick();
    wb_rst_i = 1'b0;
    held = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check($sformatf("reset_quiet_c%0d", c), '0);
    end
    run_frame(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
